// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with HI/LO registers: 32 shift-add or
// restoring shift-subtract steps on operand magnitudes, then one sign-fix cycle.
module mdu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        mf,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [1:0]  opr;
   logic        sa, sb;
   logic [31:0] aorig;
   logic [31:0] m;
   logic [63:0] p;

   logic        sgn_a, sgn_b;
   logic [31:0] abs_a, abs_b;
   logic [32:0] msum;
   logic [32:0] drem;
   logic [33:0] ddiff;
   logic [63:0] p_step;
   logic [63:0] prod;
   logic [31:0] quo, rem;
   logic [31:0] res_hi, res_lo;

   assign sgn_a = ~op[0] & a[31];
   assign sgn_b = ~op[0] & b[31];
   assign abs_a = sgn_a ? -a : a;
   assign abs_b = sgn_b ? -b : b;

   assign stall = busy & (mf | mthi | mtlo | start);

   // p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      msum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
      drem   = {p[63:32], p[31]};
      ddiff  = {1'b0, drem} - {2'b00, m};
      p_step = {msum, p[31:1]};
      if (opr[1]) begin
         if (!ddiff[33])
            p_step = {ddiff[31:0], p[30:0], 1'b1};
         else
            p_step = {drem[31:0], p[30:0], 1'b0};
      end
   end

   always_comb begin
      prod   = (sa ^ sb) ? -p : p;
      quo    = (sa ^ sb) ? -p[31:0] : p[31:0];
      rem    = sa ? -p[63:32] : p[63:32];
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      if (opr[1]) begin
         if (m == 32'd0) begin
            res_hi = aorig;
            res_lo = '1;
         end else begin
            res_hi = rem;
            res_lo = quo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opr   <= op;
                  sa    <= sgn_a;
                  sb    <= sgn_b;
                  aorig <= a;
                  m     <= abs_b;
                  p     <= {32'd0, abs_a};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            CALC: begin
               if (cnt == 6'd32) begin
                  state <= FIX;
               end else begin
                  p   <= p_step;
                  cnt <= cnt + 6'd1;
               end
            end
            FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL have port: start  input  1  request to begin a multiply/divide; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have port: a  input  32  rs operand (multiplicand/dividend).
REQ-006 SHALL have port: b  input  32  rt operand (multiplier/divisor).
REQ-007 SHALL have port: mthi  input  1  write wdata to HI.
REQ-008 SHALL have port: mtlo  input  1  write wdata to LO.
REQ-009 SHALL have port: wdata  input  32  data for mthi/mtlo.
REQ-010 SHALL have port: mf  input  1  decoder indicates an mfhi/mflo read this cycle.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-013 SHALL have port: stall  output  1  freeze request to the pipeline/PC.
REQ-014 SHALL have port: hi  output  32  HI register.
REQ-015 SHALL have port: lo  output  32  LO register.

Function
REQ-016 SHALL implement the FSM IDLE -> CALC -> FIX -> IDLE with a 6-bit iteration counter.
REQ-017 In IDLE, start=1 at edge k SHALL latch op, |a|, |b|, and the sign flags (signed ops only), clear the counter, and enter CALC.
REQ-018 CALC SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly 32 cycles, then enter FIX at edge k+33.
REQ-019 FIX SHALL apply the sign correction, write HI/LO at edge k+34, return to IDLE, and drive done=1 for exactly the cycle after edge k+34.
REQ-020 Multiply results SHALL be {hi,lo} = the 64-bit product; for mult, negate the product if sign(a) xor sign(b).
REQ-021 Divide results SHALL be lo=quotient and hi=remainder; for div, quotient is negated if the signs differ and the remainder takes the sign of the dividend.
REQ-022 For a divisor of zero (div or divu), the result SHALL be hi=a (original value) and lo=0xFFFFFFFF, with the same latency.
REQ-023 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0x00000000, with no trap.
REQ-024 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-025 mthi/mtlo in IDLE SHALL update HI/LO at the next edge; mthi and mtlo together SHALL write both.
REQ-026 When start and mthi/mtlo arrive in the same IDLE cycle, start SHALL win and the move SHALL be discarded.
REQ-027 mthi/mtlo while busy SHALL be ignored and SHALL raise stall.
REQ-028 stall SHALL be combinational: busy & (mf | mthi | mtlo | start).
REQ-029 stall SHALL be 0 in the done cycle, so an mf in that cycle reads the new HI/LO.
REQ-030 Operands SHALL be captured at start; changes on a/b during CALC SHALL have no effect.

Reset
REQ-031 reset=1 at any edge SHALL force IDLE, hi=0, lo=0, counter=0, done=0 and busy=0, including mid-CALC/FIX; the aborted result is never written.
REQ-032 reset SHALL take priority over start, mthi and mtlo in the same cycle.

Verification
REQ-033 multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done in the cycle after edge k+34.
REQ-034 mult a=0xFFFFFFFD b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; div a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 divu a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 start during CALC with different operands -> ignored, and the first result is unchanged; mf=1 during CALC -> stall=1; mf in the done cycle -> stall=0.
REQ-037 reset at cycle 10 of CALC after mtlo of 0x1234 -> next cycle busy=0, hi=lo=0, and no done pulse ever follows.
REQ-038 start=1 with mthi=1 in IDLE -> operation runs, and hi equals the computed result, not wdata.
